// File: rtl/uart_pkg.sv
// Shared constants for the parametrised UART core: parity modes, TX/RX state
// encodings and the parity helper used by both directions.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_BREAK  = 3'd5;

    // Payload is zero-extended to 9 bits by the caller; extra zeros leave the XOR unchanged.
    function automatic logic calc_parity(input logic [8:0] data, input int mode);
        logic p;
        p = ^data;
        if (mode == PARITY_EVEN) begin
            return p;
        end else if (mode == PARITY_ODD) begin
            return ~p;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/uart_core_param_if.sv
// Bus-side parallel handshake between host logic and the UART core.
interface uart_core_param_if #(
    parameter int DATA_BITS = 8
) ();

    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 rx_done;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output tx_start, tx_data,
        input  tx_busy, tx_done, rx_done, rx_data, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_start, tx_data,
        output tx_busy, tx_done, rx_done, rx_data, rx_parity_err, rx_frame_err
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: loadable down-counter flagging the half-period point and
// the end of a full bit period.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic full_tc,
    output logic half_tc
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    // Reached CLKS_PER_BIT/2 cycles after a load.
    localparam logic [CW-1:0] HALF_MARK = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

    logic [CW-1:0] cnt;

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= FULL_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign full_tc = (cnt == '0);
    assign half_tc = (cnt == HALF_MARK);

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART core with parity/framing checks, false-start
// rejection and internal loopback.
//
// TX state  | meaning
// IDLE      | line high, waiting for tx_start
// START     | driving start bit
// DATA      | driving payload, LSB first
// PARITY    | driving parity bit (only when parity enabled)
// STOP      | driving stop bit(s)
//
// RX state  | meaning
// IDLE      | waiting for a synchronised 1->0 edge
// START     | waiting to mid start bit to reject glitches
// DATA      | sampling payload mid-bit
// PARITY    | sampling parity bit
// STOP      | sampling and checking every stop bit
// BREAK     | after a framing error, waiting for the line to return high
module uart_core_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = PARITY_NONE,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_core_param_if.slave bus,
    output logic             tx,
    input  logic             rx,
    input  logic             loopback
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam bit HAS_PARITY = (PARITY != PARITY_NONE);

    // ---------------- transmitter ----------------
    logic [2:0]           tx_state;
    logic [DATA_BITS-1:0] tx_shreg;
    logic [BW-1:0]        tx_bit_cnt;
    logic                 tx_par;
    logic                 tx_line;
    logic                 tx_busy_r;
    logic                 tx_done_r;
    logic                 tx_load;
    logic                 tx_full_tc;
    logic                 tx_half_unused;

    assign tx_load = (tx_state == TX_IDLE) ? bus.tx_start : tx_full_tc;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tx_load),
        .full_tc (tx_full_tc),
        .half_tc (tx_half_unused)
    );

    // TX frame sequencer; the line is registered so the pin never glitches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state   <= TX_IDLE;
            tx_shreg   <= '0;
            tx_bit_cnt <= '0;
            tx_par     <= 1'b0;
            tx_line    <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (bus.tx_start) begin
                        tx_shreg   <= bus.tx_data;
                        tx_par     <= calc_parity(9'(bus.tx_data), PARITY);
                        tx_line    <= 1'b0;
                        tx_busy_r  <= 1'b1;
                        tx_bit_cnt <= '0;
                        tx_state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_full_tc) begin
                        tx_line  <= tx_shreg[0];
                        tx_shreg <= tx_shreg >> 1;
                        tx_state <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_full_tc) begin
                        if (tx_bit_cnt == LAST_DATA) begin
                            tx_bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                tx_line  <= tx_par;
                                tx_state <= TX_PARITY;
                            end else begin
                                tx_line  <= 1'b1;
                                tx_state <= TX_STOP;
                            end
                        end else begin
                            tx_line    <= tx_shreg[0];
                            tx_shreg   <= tx_shreg >> 1;
                            tx_bit_cnt <= tx_bit_cnt + 1'b1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tx_full_tc) begin
                        tx_line  <= 1'b1;
                        tx_state <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_full_tc) begin
                        if (tx_bit_cnt == LAST_STOP) begin
                            tx_busy_r <= 1'b0;
                            tx_done_r <= 1'b1;
                            tx_state  <= TX_IDLE;
                        end else begin
                            tx_bit_cnt <= tx_bit_cnt + 1'b1;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign tx          = loopback ? 1'b1 : tx_line;
    assign bus.tx_busy = tx_busy_r;
    assign bus.tx_done = tx_done_r;

    // ---------------- receiver ----------------
    logic                 rx_sel;
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_s3;
    logic [2:0]           rx_state;
    logic [DATA_BITS-1:0] rx_shreg;
    logic [BW-1:0]        rx_bit_cnt;
    logic                 rx_par_bit;
    logic                 rx_stop_err;
    logic                 rx_load;
    logic                 rx_full_tc;
    logic                 rx_half_tc;
    logic                 rx_done_r;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_parity_err_r;
    logic                 rx_frame_err_r;

    // Loopback taps the registered TX line, not the (forced-high) pin.
    assign rx_sel = loopback ? tx_line : rx;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx_sel;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // Held loaded while idle so the start edge begins a fresh half-bit wait.
    assign rx_load = (rx_state == RX_IDLE)  ? 1'b1 :
                     (rx_state == RX_START) ? rx_half_tc : rx_full_tc;

    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (rx_load),
        .full_tc (rx_full_tc),
        .half_tc (rx_half_tc)
    );

    // RX frame sequencer; results and flags publish together on the last stop sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state        <= RX_IDLE;
            rx_shreg        <= '0;
            rx_bit_cnt      <= '0;
            rx_par_bit      <= 1'b0;
            rx_stop_err     <= 1'b0;
            rx_done_r       <= 1'b0;
            rx_data_r       <= '0;
            rx_parity_err_r <= 1'b0;
            rx_frame_err_r  <= 1'b0;
        end else begin
            rx_done_r <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_bit_cnt  <= '0;
                    rx_stop_err <= 1'b0;
                    if (rx_s3 && !rx_s2) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_half_tc) begin
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_full_tc) begin
                        rx_shreg <= {rx_s2, rx_shreg[DATA_BITS-1:1]};
                        if (rx_bit_cnt == LAST_DATA) begin
                            rx_bit_cnt <= '0;
                            rx_state   <= HAS_PARITY ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bit_cnt <= rx_bit_cnt + 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (rx_full_tc) begin
                        rx_par_bit <= rx_s2;
                        rx_state   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_full_tc) begin
                        if (rx_bit_cnt == LAST_STOP) begin
                            rx_data_r       <= rx_shreg;
                            rx_parity_err_r <= HAS_PARITY &&
                                               (rx_par_bit != calc_parity(9'(rx_shreg), PARITY));
                            rx_frame_err_r  <= rx_stop_err | !rx_s2;
                            rx_done_r       <= 1'b1;
                            rx_state        <= (rx_stop_err | !rx_s2) ? RX_BREAK : RX_IDLE;
                        end else begin
                            rx_stop_err <= rx_stop_err | !rx_s2;
                            rx_bit_cnt  <= rx_bit_cnt + 1'b1;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_s2) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    assign bus.rx_done       = rx_done_r;
    assign bus.rx_data       = rx_data_r;
    assign bus.rx_parity_err = rx_parity_err_r;
    assign bus.rx_frame_err  = rx_frame_err_r;

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: three instances (no/odd/even parity),
// CLKS_PER_BIT=4, 8 data bits, 1 stop bit.
module tb_uart_core_param;

    logic clk;
    logic rst_n;
    logic tx_n, tx_e, tx_o;
    logic rx_n, rx_e, rx_o;
    logic lb_n, lb_e, lb_o;

    int errors = 0;
    int checks = 0;
    int rxd_n = 0;
    int rxd_e = 0;
    int rxd_o = 0;
    int txn_low = 0;

    uart_core_param_if #(.DATA_BITS(8)) if_n ();
    uart_core_param_if #(.DATA_BITS(8)) if_e ();
    uart_core_param_if #(.DATA_BITS(8)) if_o ();

    uart_core_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(if_n), .tx(tx_n), .rx(rx_n), .loopback(lb_n));
    uart_core_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .bus(if_e), .tx(tx_e), .rx(rx_e), .loopback(lb_e));
    uart_core_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_o (
        .clk(clk), .rst_n(rst_n), .bus(if_o), .tx(tx_o), .rx(rx_o), .loopback(lb_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if_n.rx_done) rxd_n++;
        if (if_e.rx_done) rxd_e++;
        if (if_o.rx_done) rxd_o++;
        if (tx_n !== 1'b1) txn_low++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive rx_e LSB-first, 4 cycles per bit, starting at a negedge.
    task automatic send_rx_e(input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx_e = bits[i];
            repeat (4) @(negedge clk);
        end
    endtask

    // Loopback frame on dut_n; optionally pulse tx_start with 8'hFF mid-frame.
    task automatic run_n(input logic [7:0] d, input bit inject, output int tx_at, output int rx_at);
        if_n.tx_data  = d;
        if_n.tx_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if_n.tx_start = 1'b0;
        tx_at = 0;
        rx_at = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (inject && n == 15) begin
                if_n.tx_data  = 8'hFF;
                if_n.tx_start = 1'b1;
            end
            if (n == 16) if_n.tx_start = 1'b0;
            if (if_n.tx_done && tx_at == 0) tx_at = n;
            if (if_n.rx_done && rx_at == 0) rx_at = n;
        end
    endtask

    initial begin
        int tx_at, rx_at, base_n, base_e, base_o;
        logic [15:0] frame;

        rst_n = 1'b0;
        rx_n = 1'b1; rx_e = 1'b1; rx_o = 1'b1;
        lb_n = 1'b1; lb_e = 1'b0; lb_o = 1'b0;
        if_n.tx_start = 1'b0; if_n.tx_data = 8'h00;
        if_e.tx_start = 1'b0; if_e.tx_data = 8'h00;
        if_o.tx_start = 1'b0; if_o.tx_data = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst tx_e", tx_e, 1);
        check("rst busy_e", if_e.tx_busy, 0);
        check("rst tx_done_e", if_e.tx_done, 0);
        check("rst rx_done_e", if_e.rx_done, 0);
        check("rst rx_data_e", if_e.rx_data, 0);
        check("rst perr_e", if_e.rx_parity_err, 0);
        check("rst ferr_e", if_e.rx_frame_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 loopback 0x41
        base_n = rxd_n;
        run_n(8'h41, 1'b0, tx_at, rx_at);
        check("8N1 tx_done cycle", tx_at, 40);
        check("8N1 rx_done cycle", rx_at, 41);
        check("8N1 rx_done count", rxd_n - base_n, 1);
        check("8N1 rx_data", if_n.rx_data, 8'h41);
        check("8N1 perr", if_n.rx_parity_err, 0);
        check("8N1 ferr", if_n.rx_frame_err, 0);

        // Parity bit on the pin: even -> 0, odd -> 1 for 0x41
        if_e.tx_data = 8'h41; if_o.tx_data = 8'h41;
        if_e.tx_start = 1'b1; if_o.tx_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if_e.tx_start = 1'b0; if_o.tx_start = 1'b0;
        check("par busy_e", if_e.tx_busy, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("par start bit", tx_e, 0);
        repeat (36) @(posedge clk);
        @(negedge clk);
        check("par bit even", tx_e, 0);
        check("par bit odd", tx_o, 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("par done early", if_e.tx_done, 0);
        @(posedge clk);
        @(negedge clk);
        check("par done even", if_e.tx_done, 1);
        check("par done odd", if_o.tx_done, 1);
        check("par busy drop", if_e.tx_busy, 0);
        repeat (4) @(negedge clk);

        // Parity frames in loopback
        lb_e = 1'b1; lb_o = 1'b1;
        base_e = rxd_e; base_o = rxd_o;
        @(negedge clk);
        if_e.tx_start = 1'b1; if_o.tx_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if_e.tx_start = 1'b0; if_o.tx_start = 1'b0;
        repeat (60) @(negedge clk);
        check("lb even count", rxd_e - base_e, 1);
        check("lb even data", if_e.rx_data, 8'h41);
        check("lb even perr", if_e.rx_parity_err, 0);
        check("lb odd count", rxd_o - base_o, 1);
        check("lb odd data", if_o.rx_data, 8'h41);
        check("lb odd perr", if_o.rx_parity_err, 0);
        check("lb odd ferr", if_o.rx_frame_err, 0);
        lb_e = 1'b0; lb_o = 1'b0;
        repeat (4) @(negedge clk);

        // External even-parity frame with wrong parity bit
        base_e = rxd_e;
        frame = {5'b0, 1'b1, 1'b1, 8'h41, 1'b0};
        send_rx_e(frame, 11);
        rx_e = 1'b1;
        repeat (8) @(negedge clk);
        check("perr count", rxd_e - base_e, 1);
        check("perr data", if_e.rx_data, 8'h41);
        check("perr flag", if_e.rx_parity_err, 1);
        check("perr ferr", if_e.rx_frame_err, 0);

        // Stop bit low, then line held low for 3 bit times
        base_e = rxd_e;
        frame = {5'b0, 1'b0, 1'b0, 8'h41, 1'b0};
        send_rx_e(frame, 11);
        repeat (12) @(negedge clk);
        check("ferr count", rxd_e - base_e, 1);
        check("ferr flag", if_e.rx_frame_err, 1);
        check("ferr perr", if_e.rx_parity_err, 0);
        check("ferr data", if_e.rx_data, 8'h41);
        rx_e = 1'b1;
        repeat (8) @(negedge clk);
        check("break release count", rxd_e - base_e, 1);

        // Short low glitch: false start
        rx_e = 1'b0;
        @(negedge clk);
        rx_e = 1'b1;
        repeat (16) @(negedge clk);
        check("glitch count", rxd_e - base_e, 1);
        check("glitch ferr held", if_e.rx_frame_err, 1);
        check("glitch data held", if_e.rx_data, 8'h41);

        // Good frame after break recovery
        frame = {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0};
        send_rx_e(frame, 11);
        rx_e = 1'b1;
        repeat (8) @(negedge clk);
        check("recover count", rxd_e - base_e, 2);
        check("recover data", if_e.rx_data, 8'h3C);
        check("recover ferr", if_e.rx_frame_err, 0);
        check("recover perr", if_e.rx_parity_err, 0);

        // tx_start mid-frame ignored
        base_n = rxd_n;
        run_n(8'h96, 1'b1, tx_at, rx_at);
        check("ignore tx_done cycle", tx_at, 40);
        check("ignore rx_done cycle", rx_at, 41);
        check("ignore count", rxd_n - base_n, 1);
        check("ignore data", if_n.rx_data, 8'h96);

        // Reset mid-DATA
        base_n = rxd_n;
        if_n.tx_data = 8'h41; if_e.tx_data = 8'h00;
        if_n.tx_start = 1'b1; if_e.tx_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if_n.tx_start = 1'b0; if_e.tx_start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("mid data tx_e", tx_e, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst mid tx_e", tx_e, 1);
        check("rst mid busy_e", if_e.tx_busy, 0);
        check("rst mid busy_n", if_n.tx_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("rst mid no rx_done", rxd_n - base_n, 0);

        // Loopback 0x5A after reset
        run_n(8'h5A, 1'b0, tx_at, rx_at);
        check("post rst tx_done cycle", tx_at, 40);
        check("post rst count", rxd_n - base_n, 1);
        check("post rst data", if_n.rx_data, 8'h5A);
        check("post rst perr", if_n.rx_parity_err, 0);
        check("post rst ferr", if_n.rx_frame_err, 0);

        check("loopback tx pin high", txn_low, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
Parametrised full-duplex UART core: transmitter and receiver sharing one clock, with configurable data width, parity mode, stop-bit count and bit period. Next-generation replacement for the fixed 8N1 uart_top. Adds receive error detection (parity, framing), false-start rejection and an internal loopback mode. Sits between bus-side logic (parallel handshake) and the board serial pins.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal >= 4
DATA_BITS, 8, payload bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal 1 or 2

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
tx_start  in  1  request to send tx_data; accepted only when tx_busy=0
tx_data  in  DATA_BITS  payload to send, LSB first
tx_busy  out  1  transmitter frame in progress
tx_done  out  1  one-cycle pulse at end of last stop bit
tx  out  1  serial output, idle high
rx  in  1  serial input, asynchronous, idle high
loopback  in  1  1 = receiver fed from internal tx, tx pin held high
rx_done  out  1  one-cycle pulse, frame received
rx_data  out  DATA_BITS  last received payload
rx_parity_err  out  1  parity mismatch on last frame
rx_frame_err  out  1  a stop bit sampled low on last frame

Behaviour:
- Clock is clk; reset is synchronous, active-low, sampled on the rising clk edge. One clock domain.
- Reset values: tx=1, tx_busy=0, tx_done=0, rx_done=0, rx_data=0, both error flags 0, both FSMs in IDLE, counters 0. Reset mid-frame aborts immediately; tx is 1 on the first edge with rst_n low.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - In IDLE, tx_start=1 latches tx_data and sets tx_busy on the same edge. tx drives start bit 0 from the next cycle.
  - Each bit is held exactly CLKS_PER_BIT cycles. Data is sent LSB first. Parity bit = XOR of data (even) or its inverse (odd).
  - tx_start while tx_busy=1 is ignored; the latched data is unaffected.
  - tx_done pulses and tx_busy drops on the cycle after the final stop-bit period. A new tx_start may be accepted on that same cycle. Back-to-back frames have no idle gap.
  - Frame length = CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- RX input selection and synchronisation:
  - Receiver input = loopback ? internal tx : rx.
  - The input passes through a 2-flop synchroniser; all sampling uses the synchronised value.
  - When loopback=1, the tx pin is forced to 1.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE, plus BREAK.
  - IDLE: a synchronised 1->0 transition enters START.
  - START: wait CLKS_PER_BIT/2 cycles and resample. If 1, it is a false start: return to IDLE with no rx_done and no flag change.
  - Subsequent samples are taken every CLKS_PER_BIT cycles at mid-bit: DATA_BITS data bits, then parity, then STOP_BITS stop bits. Every stop bit is checked.
  - At the last stop sample, rx_data, rx_parity_err and rx_frame_err update together and rx_done pulses one cycle. Outputs hold until the next rx_done.
  - rx_done asserts even on error; the flags qualify the frame.
  - Frame error: enter BREAK after rx_done; stay until the line is sampled high, then go to IDLE. No new start bit is detected while the line is low.
  - The next start edge may be detected on the cycle after the STOP sample, so mid-stop-bit resynchronisation is allowed.
- Loopback change mid-frame: must not lock up. Both FSMs return to IDLE within one frame time plus one bit. The affected frame may be flagged or corrupted.
- Width rules: the bit counter spans DATA_BITS. The baud counter is clog2(CLKS_PER_BIT) bits, with terminal count CLKS_PER_BIT-1.

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants
  - TX and RX state encodings
  - a function computing parity from data and mode
- One sub-module is natural: uart_baud_cnt, a loadable down-counter with half-period and full-period terminal outputs, instantiated once in TX and once in RX.
- TX and RX FSMs live in the top.

Test Plan:
- CLKS_PER_BIT=4, 8N1, loopback=1, tx_data=8'h41 -> tx_done after 40 cycles; rx_done with rx_data=8'h41, both flags 0; tx pin stays 1.
- PARITY=2, 8'h41 -> transmitted parity bit 0. PARITY=1, 8'h41 -> parity bit 1. In loopback, both give rx_data=8'h41 with no error.
- External rx, PARITY=2, frame 8'h41 with parity bit driven 1 -> rx_done, rx_data=8'h41, rx_parity_err=1.
- External rx frame with stop bit 0, line then held low for 3 bit times -> rx_frame_err=1; no second rx_done until the line returns high and a new start bit arrives.
- Low glitch on rx of CLKS_PER_BIT/2-1 cycles -> no rx_done, flags unchanged. Also: tx_start pulsed mid-frame with 8'hFF -> ignored, the first frame completes unchanged.
- rst_n=0 for 1 cycle mid-DATA -> tx=1 next edge, tx_busy=0, no rx_done. A subsequent 8'h5A loopback frame is received correctly.
